// File: rtl/boa_insn_realign_if.sv
// Fetch-side and decode-side handshake bundle for the instruction realigner.
// The realigner uses the slave modport; the fetch unit / decompressor side uses master.
interface boa_insn_realign_if;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_addr;
  logic [31:0] f_data;
  logic        f_fault;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_insn;
  logic        d_comp;
  logic [31:0] d_pc;
  logic        d_fault;

  modport master (
    output f_valid, f_addr, f_data, f_fault, d_ready,
    input  f_ready, d_valid, d_insn, d_comp, d_pc, d_fault
  );

  modport slave (
    input  f_valid, f_addr, f_data, f_fault, d_ready,
    output f_ready, d_valid, d_insn, d_comp, d_pc, d_fault
  );
endinterface

// File: rtl/boa_insn_realign.sv
// Instruction realignment buffer: turns word-aligned fetch words into one RVC
// or 32-bit instruction per handshake, tracking PC, redirects and per-halfword faults.
module boa_insn_realign #(
  parameter logic [31:0] entry_pc = 32'h4000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [31:0]               flush_pc,
  boa_insn_realign_if.slave         bus
);

  logic [15:0] hw  [3];
  logic        flt [3];
  logic [1:0]  count;
  logic [31:0] head_pc;
  logic [29:0] fetch_addr;
  logic        skip_lo;

  logic        is16, comp, valid, pop, push;
  logic [1:0]  pop_len, push_len, keep, keep1;
  logic [15:0] sh_hw  [3];
  logic        sh_flt [3];
  logic [15:0] n_hw   [3];
  logic        n_flt  [3];

  // Address bits the fetch/redirect protocol defines as don't-care.
  logic unused_bits;
  assign unused_bits = ^{bus.f_addr[1:0], flush_pc[0]};

  assign is16  = hw[0][1:0] != 2'b11;
  assign comp  = is16 | flt[0];
  assign valid = !flush && (count != 2'd0) && (comp || count >= 2'd2);

  assign bus.f_ready = flush || (count <= 2'd1);
  assign bus.d_valid = valid;
  assign bus.d_comp  = comp;
  assign bus.d_insn  = comp ? {16'h0000, hw[0]} : {hw[1], hw[0]};
  assign bus.d_pc    = head_pc;
  assign bus.d_fault = flt[0] | (!is16 & flt[1]);

  assign pop      = valid && bus.d_ready;
  assign pop_len  = pop ? (comp ? 2'd1 : 2'd2) : 2'd0;
  // Stale words (address mismatch after a redirect) are accepted but discarded.
  assign push     = bus.f_valid && bus.f_ready && !flush &&
                    (bus.f_addr[31:2] == fetch_addr);
  assign push_len = push ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
  assign keep     = count - pop_len;
  assign keep1    = keep + 2'd1;

  // NOTE: every always_comb output gets a value before any conditional
  // override, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sh_hw[0]  = hw[0];
    sh_hw[1]  = hw[1];
    sh_hw[2]  = hw[2];
    sh_flt[0] = flt[0];
    sh_flt[1] = flt[1];
    sh_flt[2] = flt[2];
    if (pop_len == 2'd1) begin
      sh_hw[0]  = hw[1];  sh_hw[1]  = hw[2];  sh_hw[2]  = 16'h0000;
      sh_flt[0] = flt[1]; sh_flt[1] = flt[2]; sh_flt[2] = 1'b0;
    end else if (pop_len == 2'd2) begin
      sh_hw[0]  = hw[2];  sh_hw[1]  = 16'h0000; sh_hw[2]  = 16'h0000;
      sh_flt[0] = flt[2]; sh_flt[1] = 1'b0;     sh_flt[2] = 1'b0;
    end

    // Pushes only happen at count<=1, so appended halfwords always fit.
    for (int i = 0; i < 3; i++) begin
      n_hw[i]  = sh_hw[i];
      n_flt[i] = sh_flt[i];
      if (push && i[1:0] == keep) begin
        n_hw[i]  = skip_lo ? bus.f_data[31:16] : bus.f_data[15:0];
        n_flt[i] = bus.f_fault;
      end
      if (push && !skip_lo && i[1:0] == keep1) begin
        n_hw[i]  = bus.f_data[31:16];
        n_flt[i] = bus.f_fault;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_pc    <= {entry_pc[31:1], 1'b0};
      fetch_addr <= entry_pc[31:2];
      skip_lo    <= entry_pc[1];
      // NOTE: the buffer contents are reset because d_insn/d_comp/d_fault
      // are visible from reset and must read as an idle RVC zero parcel.
      for (int i = 0; i < 3; i++) begin
        hw[i]  <= 16'h0000;
        flt[i] <= 1'b0;
      end
    end else if (flush) begin
      count      <= 2'd0;
      head_pc    <= {flush_pc[31:1], 1'b0};
      fetch_addr <= flush_pc[31:2];
      skip_lo    <= flush_pc[1];
    end else begin
      count   <= keep + push_len;
      hw      <= n_hw;
      flt     <= n_flt;
      head_pc <= head_pc + {29'd0, pop_len, 1'b0};
      if (push) begin
        fetch_addr <= fetch_addr + 30'd1;
        skip_lo    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boa_insn_realign.sv
// Directed bench for boa_insn_realign: scoreboard of expected instructions
// popped on every output handshake, plus point checks on handshake/state.
module tb_boa_insn_realign;

  typedef struct packed {
    logic [31:0] insn;
    logic        comp;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb [$];

  boa_insn_realign_if bus ();

  boa_insn_realign #(.entry_pc(32'h4000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .flush_pc (flush_pc),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_insn(input logic [31:0] insn, input logic comp,
                             input logic [31:0] pc, input logic fault);
    sb.push_back('{insn: insn, comp: comp, pc: pc, fault: fault});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush    = 1'b0;
  endtask

  // Present one fetch word and hold it until the realigner accepts it.
  task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic fault);
    logic ok;
    bus.f_valid = 1'b1;
    bus.f_addr  = addr;
    bus.f_data  = data;
    bus.f_fault = fault;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.f_ready;
    end
    check("send_accept", {31'd0, ok}, 32'd1);
    if (ok) tick();
    bus.f_valid = 1'b0;
    bus.f_fault = 1'b0;
  endtask

  // Every output handshake is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.d_valid && bus.d_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pc", bus.d_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_insn",  bus.d_insn, e.insn);
        check("sb_comp",  {31'd0, bus.d_comp}, {31'd0, e.comp});
        check("sb_pc",    bus.d_pc, e.pc);
        check("sb_fault", {31'd0, bus.d_fault}, {31'd0, e.fault});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    bus.f_valid = 1'b0;
    bus.f_addr  = 32'h0;
    bus.f_data  = 32'h0;
    bus.f_fault = 1'b0;
    bus.d_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check("rst_d_pc",    bus.d_pc, 32'h4000_0000);
    check("rst_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check("rst_d_insn",  bus.d_insn, 32'h0);
    check("rst_d_comp",  {31'd0, bus.d_comp}, 32'd1);
    check("rst_d_fault", {31'd0, bus.d_fault}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Entry PC: two RVC parcels on consecutive cycles
    expect_insn(32'h0000_0505, 1'b1, 32'h4000_0000, 1'b0);
    expect_insn(32'h0000_0001, 1'b1, 32'h4000_0002, 1'b0);
    send(32'h4000_0000, 32'h0001_0505, 1'b0);
    tick();
    check("entry_second_valid", {31'd0, bus.d_valid}, 32'd1);
    check("entry_second_pc",    bus.d_pc, 32'h4000_0002);
    tick();
    check("entry_drained", {31'd0, bus.d_valid}, 32'd0);

    // Straddling 32-bit instruction
    do_flush(32'h0);
    expect_insn(32'h0000_4501, 1'b1, 32'h0, 1'b0);
    send(32'h0, 32'h0093_4501, 1'b0);
    tick();
    check("straddle_wait0", {31'd0, bus.d_valid}, 32'd0);
    check("straddle_f_ready", {31'd0, bus.f_ready}, 32'd1);
    tick();
    check("straddle_wait1", {31'd0, bus.d_valid}, 32'd0);
    expect_insn(32'h0010_0093, 1'b0, 32'h2, 1'b0);
    expect_insn(32'h0000_0000, 1'b1, 32'h6, 1'b0);
    send(32'h4, 32'h0000_0010, 1'b0);
    check("straddle_comp",  {31'd0, bus.d_comp}, 32'd0);
    check("straddle_full_f_ready", {31'd0, bus.f_ready}, 32'd0);
    tick();
    check("straddle_tail_valid", {31'd0, bus.d_valid}, 32'd1);
    check("straddle_tail_pc",    bus.d_pc, 32'h6);
    check("straddle_tail_f_ready", {31'd0, bus.f_ready}, 32'd1);
    tick();
    check("straddle_drained", {31'd0, bus.d_valid}, 32'd0);

    // Flush to odd halfword; stale word dropped
    do_flush(32'h102);
    send(32'h200, 32'hDEAD_BEEF, 1'b0);
    check("stale_dropped", {31'd0, bus.d_valid}, 32'd0);
    expect_insn(32'h0000_4585, 1'b1, 32'h102, 1'b0);
    send(32'h100, 32'h4585_1111, 1'b0);
    tick();
    check("odd_drained", {31'd0, bus.d_valid}, 32'd0);

    // Backpressure, then release with a concurrent push
    bus.d_ready = 1'b0;
    expect_insn(32'h0000_0001, 1'b1, 32'h104, 1'b0);
    expect_insn(32'h0000_0005, 1'b1, 32'h106, 1'b0);
    expect_insn(32'h0000_0005, 1'b1, 32'h108, 1'b0);
    expect_insn(32'h0000_0009, 1'b1, 32'h10A, 1'b0);
    send(32'h104, 32'h0005_0001, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("bp_f_ready", {31'd0, bus.f_ready}, 32'd0);
      check("bp_d_valid", {31'd0, bus.d_valid}, 32'd1);
      check("bp_d_insn",  bus.d_insn, 32'h0000_0001);
      check("bp_d_pc",    bus.d_pc, 32'h104);
      tick();
    end
    bus.d_ready = 1'b1;
    send(32'h108, 32'h0009_0005, 1'b0);
    check("bp_push_pop_f_ready", {31'd0, bus.f_ready}, 32'd0);
    check("bp_push_pop_pc",      bus.d_pc, 32'h108);
    check("bp_push_pop_valid",   {31'd0, bus.d_valid}, 32'd1);
    tick();
    tick();
    check("bp_drained", {31'd0, bus.d_valid}, 32'd0);

    // Fault on the second half of a straddling instruction
    do_flush(32'h0);
    expect_insn(32'h0000_0001, 1'b1, 32'h0, 1'b0);
    send(32'h0, 32'h0013_0001, 1'b0);
    tick();
    check("fault_wait", {31'd0, bus.d_valid}, 32'd0);
    expect_insn(32'h1234_0013, 1'b0, 32'h2, 1'b1);
    expect_insn(32'h0000_ABCD, 1'b1, 32'h6, 1'b1);
    send(32'h4, 32'hABCD_1234, 1'b1);
    tick();
    tick();
    check("fault_drained", {31'd0, bus.d_valid}, 32'd0);

    // Flush coincident with fetch and output handshakes
    bus.d_ready = 1'b0;
    send(32'h8, 32'h0003_0001, 1'b0);
    flush       = 1'b1;
    flush_pc    = 32'h301;
    bus.d_ready = 1'b1;
    bus.f_valid = 1'b1;
    bus.f_addr  = 32'hC;
    bus.f_data  = 32'h0007_0007;
    #1;
    check("flush_gates_valid", {31'd0, bus.d_valid}, 32'd0);
    check("flush_f_ready",     {31'd0, bus.f_ready}, 32'd1);
    tick();
    flush       = 1'b0;
    bus.f_valid = 1'b0;
    check("flush_empty",   {31'd0, bus.d_valid}, 32'd0);
    check("flush_pc_out",  bus.d_pc, 32'h300);
    expect_insn(32'h0000_0001, 1'b1, 32'h300, 1'b0);
    expect_insn(32'h0000_0000, 1'b1, 32'h302, 1'b0);
    send(32'h300, 32'h0000_0001, 1'b0);
    tick();
    tick();
    check("flush_drained", {31'd0, bus.d_valid}, 32'd0);

    // Address wrap-around
    do_flush(32'hFFFF_FFFC);
    expect_insn(32'h0000_0001, 1'b1, 32'hFFFF_FFFC, 1'b0);
    expect_insn(32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b0);
    expect_insn(32'h0000_0005, 1'b1, 32'h0, 1'b0);
    expect_insn(32'h0000_0005, 1'b1, 32'h2, 1'b0);
    send(32'hFFFF_FFFC, 32'h0001_0001, 1'b0);
    send(32'h0, 32'h0005_0005, 1'b0);
    tick();
    tick();
    tick();
    check("wrap_drained", {31'd0, bus.d_valid}, 32'd0);

    // Reset mid-operation overrides flush
    bus.d_ready = 1'b0;
    send(32'h4, 32'h0001_0001, 1'b0);
    check("pre_reset_valid", {31'd0, bus.d_valid}, 32'd1);
    rst_n    = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h500;
    tick();
    flush = 1'b0;
    #1;
    check("midrst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check("midrst_d_pc",    bus.d_pc, 32'h4000_0000);
    check("midrst_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check("midrst_d_insn",  bus.d_insn, 32'h0);
    check("midrst_d_comp",  {31'd0, bus.d_comp}, 32'd1);
    rst_n = 1'b1;
    tick();

    check("sb_leftover", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
